// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// size/byte-mask helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      WR1,
      WR2,
      RD1,
      RD2,
      RD3,
      RESP_ERR
   } lsu_state_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
      case (f3_lo)
         2'd0:    size_bytes = 3'd1;
         2'd1:    size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] byte_mask(input logic [1:0] f3_lo);
      case (f3_lo)
         2'd0:    byte_mask = 4'b0001;
         2'd1:    byte_mask = 4'b0011;
         default: byte_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift/mask for both beats of an access and
// load combine/extract/extend from the low and high words.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_lo,
   input  logic [31:0] i_hi,
   output logic [3:0]  o_we1,
   output logic [3:0]  o_we2,
   output logic [31:0] o_data1,
   output logic [31:0] o_data2,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_mask_sh;
   logic [63:0] w_data_sh;
   logic [63:0] w_rd_sh;
   logic [31:0] w_raw;

   // Shifting into a double-width field yields beat 1 in the low half and the
   // spill-over bytes of a crossing access in the high half.
   always_comb begin
      w_mask_sh = {4'b0000, byte_mask(i_funct3[1:0])} << i_off;
      w_data_sh = {32'h0, i_wdata} << {i_off, 3'b000};
      w_rd_sh   = {i_hi, i_lo} >> {i_off, 3'b000};
      w_raw     = w_rd_sh[31:0];
      case (i_funct3[1:0])
         2'd0:    o_rdata = i_funct3[2] ? {24'h0, w_raw[7:0]}
                                        : {{24{w_raw[7]}}, w_raw[7:0]};
         2'd1:    o_rdata = i_funct3[2] ? {16'h0, w_raw[15:0]}
                                        : {{16{w_raw[15]}}, w_raw[15:0]};
         default: o_rdata = w_raw;
      endcase
   end

   assign o_we1   = w_mask_sh[3:0];
   assign o_we2   = w_mask_sh[7:4];
   assign o_data1 = w_data_sh[31:0];
   assign o_data2 = w_data_sh[63:32];

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit driving the bram_dmem port: one request at a time, split
// into one or two word beats, single-cycle response pulse.
module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [3:0]        mem_we,
   output logic              mem_write_only,
   output logic [ADDR_W-1:0] mem_daddr,
   output logic [31:0]       mem_datain,
   input  logic [31:0]       mem_outdata
);

   lsu_state_e        r_state, w_next;
   logic              r_ready, r_resp_valid, r_resp_err, r_mem_wo;
   logic [31:0]       r_resp_rdata, r_mem_datain, r_wdata, r_lo;
   logic [3:0]        r_mem_we;
   logic [ADDR_W-1:0] r_mem_daddr, r_word;
   logic [2:0]        r_f3;
   logic [1:0]        r_off;

   logic [2:0]        w_f3, w_size;
   logic [1:0]        w_off;
   logic [ADDR_W-1:0] w_word;
   logic [31:0]       w_wdata, w_lo;
   logic              w_cross, w_bad_f3, w_err, w_acc;
   logic [3:0]        w_we1, w_we2, w_mem_we_d;
   logic [31:0]       w_data1, w_data2, w_rdata, w_mem_datain_d, w_resp_rdata_d;
   logic [ADDR_W-1:0] w_mem_daddr_d;
   logic              w_mem_wo_d, w_resp_valid_d, w_resp_err_d;

   // Live request fields while idle so the first beat registers on the accept edge.
   always_comb begin
      w_f3     = (r_state == IDLE) ? req_funct3 : r_f3;
      w_off    = (r_state == IDLE) ? req_addr[1:0] : r_off;
      w_word   = (r_state == IDLE) ? req_addr[ADDR_W+1:2] : r_word;
      w_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
      w_size   = size_bytes(w_f3[1:0]);
      w_cross  = (({1'b0, w_off} + w_size) > 3'd4);
      w_lo     = w_cross ? r_lo : mem_outdata;
      w_bad_f3 = req_we ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                        : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      w_err    = w_bad_f3 || (req_addr[31:ADDR_W+2] != '0) || (w_cross && (&w_word));
      w_acc    = req_valid && r_ready;
   end

   lsu_align u_align (
      .i_funct3 (w_f3),
      .i_off    (w_off),
      .i_wdata  (w_wdata),
      .i_lo     (w_lo),
      .i_hi     (mem_outdata),
      .o_we1    (w_we1),
      .o_we2    (w_we2),
      .o_data1  (w_data1),
      .o_data2  (w_data2),
      .o_rdata  (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_acc) w_next = w_err ? RESP_ERR : (req_we ? WR1 : RD1);
         WR1:      w_next = w_cross ? WR2 : IDLE;
         RD1:      w_next = w_cross ? RD2 : RD3;
         RD2:      w_next = RD3;
         default:  w_next = IDLE;
      endcase
   end

   always_comb begin
      w_mem_we_d     = '0;
      w_mem_wo_d     = 1'b0;
      w_mem_datain_d = '0;
      w_mem_daddr_d  = r_mem_daddr;
      w_resp_valid_d = 1'b0;
      w_resp_err_d   = 1'b0;
      w_resp_rdata_d = '0;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               if (w_err) begin
                  w_resp_valid_d = 1'b1;
                  w_resp_err_d   = 1'b1;
               end else begin
                  w_mem_daddr_d = w_word;
                  if (req_we) begin
                     w_mem_we_d     = w_we1;
                     w_mem_wo_d     = 1'b1;
                     w_mem_datain_d = w_data1;
                     w_resp_valid_d = !w_cross;
                  end
               end
            end
         end
         WR1: begin
            if (w_cross) begin
               w_mem_daddr_d  = w_word + ADDR_W'(1);
               w_mem_we_d     = w_we2;
               w_mem_wo_d     = 1'b1;
               w_mem_datain_d = w_data2;
               w_resp_valid_d = 1'b1;
            end
         end
         RD1: begin
            if (w_cross) w_mem_daddr_d = w_word + ADDR_W'(1);
         end
         RD3: begin
            w_resp_valid_d = 1'b1;
            w_resp_rdata_d = w_rdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ready      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
         r_mem_we     <= '0;
         r_mem_wo     <= 1'b0;
         r_mem_daddr  <= '0;
         r_mem_datain <= '0;
         r_f3         <= '0;
         r_off        <= '0;
         r_word       <= '0;
         r_wdata      <= '0;
         r_lo         <= '0;
      end else begin
         // Ready stays low through the response pulse and rises the cycle after.
         r_ready      <= (w_next == IDLE) && !w_resp_valid_d;
         r_resp_valid <= w_resp_valid_d;
         r_resp_err   <= w_resp_err_d;
         r_resp_rdata <= w_resp_rdata_d;
         r_mem_we     <= w_mem_we_d;
         r_mem_wo     <= w_mem_wo_d;
         r_mem_daddr  <= w_mem_daddr_d;
         r_mem_datain <= w_mem_datain_d;
         if (r_state == IDLE && w_acc) begin
            r_f3    <= req_funct3;
            r_off   <= req_addr[1:0];
            r_word  <= req_addr[ADDR_W+1:2];
            r_wdata <= req_wdata;
         end
         if (r_state == RD2) r_lo <= mem_outdata;
      end
   end

   assign req_ready      = r_ready;
   assign resp_valid     = r_resp_valid;
   assign resp_rdata     = r_resp_rdata;
   assign resp_err       = r_resp_err;
   assign mem_we         = r_mem_we;
   assign mem_write_only = r_mem_wo;
   assign mem_daddr      = r_mem_daddr;
   assign mem_datain     = r_mem_datain;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem against a behavioural bram_dmem model.
module tb_lsu_dmem;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [3:0]        mem_we;
   logic              mem_write_only;
   logic [ADDR_W-1:0] mem_daddr;
   logic [31:0]       mem_datain;
   logic [31:0]       mem_outdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   lsu_dmem #(.ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_we         (mem_we),
      .mem_write_only (mem_write_only),
      .mem_daddr      (mem_daddr),
      .mem_datain     (mem_datain),
      .mem_outdata    (mem_outdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read, byte-writable word memory.
   always @(posedge clk) begin
      if (mem_write_only) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_daddr][8*b +: 8] <= mem_datain[8*b +: 8];
      end else begin
         mem_outdata <= mem[mem_daddr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
      chk("ready_before_req", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      step();
      req_valid  = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [31:0] daddr, input logic [3:0] we,
                       input logic [31:0] din, input logic rv);
      chk({tag, "_daddr"}, 32'(mem_daddr), daddr);
      chk({tag, "_we"}, 32'(mem_we), 32'(we));
      chk({tag, "_wo"}, 32'(mem_write_only), 32'd1);
      chk({tag, "_datain"}, mem_datain, din);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(rv));
      chk({tag, "_ready"}, 32'(req_ready), 32'd0);
   endtask

   task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp, input int lat);
      issue(1'b0, f3, addr, 32'h0);
      chk({tag, "_rd_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_rd_wo"}, 32'(mem_write_only), 32'd0);
      for (int k = 0; k < lat; k++) begin
         chk({tag, "_early_resp"}, 32'(resp_valid), 32'd0);
         step();
      end
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_rdata"}, resp_rdata, exp);
      chk({tag, "_err"}, 32'(resp_err), 32'd0);
      chk({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
      step();
      chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
      chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic err_check(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
      issue(we, f3, addr, 32'h12345678);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_err"}, 32'(resp_err), 32'd1);
      chk({tag, "_rdata"}, resp_rdata, 32'h0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_wo"}, 32'(mem_write_only), 32'd0);
      step();
      chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
      step();
      step();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_wo", 32'(mem_write_only), 32'd0);
      chk("rst_daddr", 32'(mem_daddr), 32'd0);
      chk("rst_datain", mem_datain, 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'd0);
      rst_n = 1'b1;
      step();
      chk("release_ready", 32'(req_ready), 32'd1);

      // SW / LW round trip
      issue(1'b1, 3'd2, 32'h10, 32'h1F0F0F0F);
      beat("sw", 32'd4, 4'b1111, 32'h1F0F0F0F, 1'b1);
      chk("sw_err", 32'(resp_err), 32'd0);
      step();
      chk("sw_ready_after", 32'(req_ready), 32'd1);
      chk("sw_we_clear", 32'(mem_we), 32'd0);
      chk("sw_wo_clear", 32'(mem_write_only), 32'd0);
      load_check("lw", 3'd2, 32'h10, 32'h1F0F0F0F, 2);

      // Byte store and sign/zero-extended byte loads
      issue(1'b1, 3'd0, 32'h13, 32'h000000AB);
      beat("sb", 32'd4, 4'b1000, 32'hAB000000, 1'b1);
      step();
      load_check("lb", 3'd0, 32'h13, 32'hFFFFFFAB, 2);
      load_check("lbu", 3'd4, 32'h13, 32'h000000AB, 2);

      // Halfword store/load crossing a word boundary
      issue(1'b1, 3'd1, 32'h07, 32'h0000BEEF);
      beat("sh_b1", 32'd1, 4'b1000, 32'hEF000000, 1'b0);
      step();
      beat("sh_b2", 32'd2, 4'b0001, 32'h000000BE, 1'b1);
      step();
      chk("sh_ready_after", 32'(req_ready), 32'd1);
      load_check("lhu_x", 3'd5, 32'h07, 32'h0000BEEF, 3);
      load_check("lh_x", 3'd1, 32'h07, 32'hFFFFBEEF, 3);

      // Rejected accesses
      err_check("err_range", 1'b0, 3'd2, 32'h00004000);
      err_check("err_topword", 1'b0, 3'd2, 32'h00003FFE);
      err_check("err_ld_f3", 1'b0, 3'd3, 32'h0);
      err_check("err_st_f3", 1'b1, 3'd4, 32'h10);
      load_check("lw_after_err", 3'd2, 32'h10, 32'hAB0F0F0F, 2);

      // Held request during a crossing load is not accepted until ready
      issue(1'b0, 3'd2, 32'h06, 32'h0);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
      for (int k = 0; k < 3; k++) begin
         chk("busy_ready", 32'(req_ready), 32'd0);
         chk("busy_no_write", 32'(mem_we), 32'd0);
         chk("busy_no_resp", 32'(resp_valid), 32'd0);
         step();
      end
      chk("lw_x_resp", 32'(resp_valid), 32'd1);
      chk("lw_x_rdata", resp_rdata, 32'h00BEEF00);
      chk("lw_x_ready_in_resp", 32'(req_ready), 32'd0);
      step();
      chk("held_ready", 32'(req_ready), 32'd1);
      chk("held_not_yet", 32'(mem_we), 32'd0);
      step();
      req_valid = 1'b0;
      beat("held_sw", 32'd0, 4'b1111, 32'hDEADBEEF, 1'b1);
      step();
      load_check("lw_held", 3'd2, 32'h0, 32'hDEADBEEF, 2);

      // Reset in the middle of a crossing load
      issue(1'b0, 3'd2, 32'h06, 32'h0);
      step();
      rst_n = 1'b0;
      step();
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_resp", 32'(resp_valid), 32'd0);
      chk("mid_rst_rdata", resp_rdata, 32'h0);
      chk("mid_rst_err", 32'(resp_err), 32'd0);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      chk("mid_rst_wo", 32'(mem_write_only), 32'd0);
      chk("mid_rst_daddr", 32'(mem_daddr), 32'd0);
      chk("mid_rst_datain", mem_datain, 32'h0);
      step();
      chk("mid_rst_resp_hold", 32'(resp_valid), 32'd0);
      rst_n = 1'b1;
      step();
      chk("mid_rst_release_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_release_resp", 32'(resp_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
Load/store unit on the core side of the data-memory port. It is the initiator that drives bram_dmem (we, write_only, daddr, datain) and consumes its outdata.
- Accepts one RV32I load/store request at a time.
- Generates byte-lane enables and shifts write data into the correct lanes.
- Splits misaligned accesses that cross a word boundary into two word beats.
- Returns sign- or zero-extended load data, or an error, on a one-cycle response pulse.

Parameters:
ADDR_W, 12, word-index width of bram_dmem (4K words).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU idle and able to accept
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_err  out  1  access rejected, no memory side effect
mem_we  out  4  byte write enables to bram_dmem
mem_write_only  out  1  1 during write beats
mem_daddr  out  ADDR_W  word index to bram_dmem
mem_datain  out  32  lane-aligned write data
mem_outdata  in  32  read data, valid one cycle after daddr is presented with write_only=0

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0 while rst_n=0, 1 on the first cycle after release. mem_we=0, mem_write_only=0, mem_daddr=0, mem_datain=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Accept when req_valid && req_ready at edge T. Latch all req fields. req_ready drops from T+1 until the cycle after resp_valid.
- Decode:
  - size = 1/2/4 bytes from funct3[1:0].
  - o = addr[1:0].
  - w = addr[ADDR_W+1:2].
  - cross = (o + size > 4).
- Error (no memory beat; resp at T+1 with err=1 and rdata=0) when any of:
  - store with funct3 > 2;
  - load with funct3 in {3,6,7};
  - addr[31:ADDR_W+2] != 0;
  - cross && w == 2^ADDR_W-1.
- States: IDLE, WR1, WR2, RD1, RD2, RD3, RESP_ERR.
- Store, non-crossing: WR1 at T+1 drives:
  - mem_daddr = w;
  - mem_we = mask(size) << o;
  - mem_datain = wdata << 8*o;
  - mem_write_only = 1.
  resp_valid at T+1. Return to IDLE.
- Store, crossing: WR1 (word w, lanes o..3) at T+1. WR2 (word w+1, lanes 0..o+size-5, remaining bytes at the bottom of mem_datain) at T+2. resp_valid at T+2.
- Load, non-crossing: RD1 at T+1 drives mem_daddr = w, mem_we = 0, mem_write_only = 0. At T+2, extract (mem_outdata >> 8*o), truncate to size, extend (funct3[2]=1 means zero-extend), and pulse resp_valid.
- Load, crossing: RD1 at T+1 (word w). RD2 at T+2 captures the low word and issues w+1. At T+3 combine ({hi, lo} >> 8*o), extend, and pulse resp_valid.
- mem_we returns to 0 in every non-write cycle. mem_write_only = 0 outside write beats.
- req_valid while busy is ignored, not queued. The master must hold the request until req_ready.
- No response backpressure: resp_valid is a single-cycle pulse.
- Reset mid-operation: next edge forces IDLE-reset values and no response is produced. A beat already presented to memory is not undone.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams;
  - state enum;
  - size decode function;
  - byte-mask function.
- One combinational sub-module, lsu_align, holds:
  - store lane shift/mask generation for beat 1 and beat 2;
  - load combine/extract/extend.
- lsu_dmem holds the FSM, request latch and registered outputs.

Test Plan:
1. SW addr 0x10 data 0x1F0F0F0F -> T+1: daddr=4, we=1111, datain=1F0F0F0F, resp_valid, err=0. Then LW 0x10 -> resp at T+2 with rdata=1F0F0F0F.
2. SB addr 0x13 data 0x000000AB -> we=1000, datain=AB000000. Then LB 0x13 -> FFFFFFAB; LBU 0x13 -> 000000AB.
3. SH addr 0x07 data 0xBEEF -> beat1 daddr=1, we=1000, datain=EF000000; beat2 daddr=2, we=0001, datain=000000BE; resp at T+2. Then LHU 0x07 -> 0000BEEF at T+3; LH 0x07 -> FFFFBEEF.
4. LW addr 0x00004000 -> resp_err=1 at T+1, mem_we stays 0. LW addr 0x00003FFE (crosses top word) -> err=1. Load funct3=3 -> err=1.
5. Second req_valid during a crossing load -> ignored, req_ready=0 until after resp. SW 0x0 issued the cycle after that resp is accepted normally.
6. Drop rst_n at T+2 of a crossing load -> no resp_valid, all outputs 0 next cycle, req_ready=1 one cycle after release.
